ram4k_arbiter: RTL



---
 rtl/ram4k_arbiter_pkg.sv | 16 +
 rtl/ram4k.sv | 29 ++
 rtl/ram4k_arbiter_arb2_pick.sv | 38 +++
 rtl/ram4k_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/ram4k_arbiter_pkg.sv
// Shared definitions for the ram4k two-port arbiter.
//   state_t          : arbiter FSM encoding (IDLE, ACC_A, ACC_B)
//   PORT_A / PORT_B  : requester identifiers used by the grant logic and
//                      the round-robin pointer
package ram4k_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC_A = 2'd1,
    ST_ACC_B = 2'd2
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/ram4k.sv
// ram4k: 4096 x 16 word memory, synchronous write, combinational read.
// Ports:
//   clk      : write clock, rising edge
//   in       : write data
//   load     : write enable, commits in -> mem[address] at the rising edge
//   address  : word address (shared by read and write)
//   out      : combinational read data mem[address]
module ram4k #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic [DATA_W-1:0] in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] out
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (load) begin
      mem[address] <= in;
    end
  end

  assign out = mem[address];

endmodule

// File: rtl/ram4k_arbiter_arb2_pick.sv
// arb2_pick: combinational two-way grant selection.
// Ports:
//   elig_a, elig_b : requester is eligible for a grant this cycle
//   last           : port granted most recently (round-robin pointer)
//   grant_valid    : at least one requester is eligible
//   grant_id       : port to be granted (meaningful when grant_valid)
// Build option ARB_FIXED_PRIO_EN: when defined, port A wins every tie and
// last is ignored; otherwise ties go to the port that was not served last.
module arb2_pick
  import ram4k_arbiter_pkg::*;
(
  input  logic elig_a,
  input  logic elig_b,
  input  logic last,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = elig_a | elig_b;
    grant_id    = PORT_A;
    if (elig_a && elig_b) begin
`ifdef ARB_FIXED_PRIO_EN
      grant_id = PORT_A;
`else
      grant_id = (last == PORT_A) ? PORT_B : PORT_A;
`endif
    end else if (elig_b) begin
      grant_id = PORT_B;
    end
  end

`ifdef ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;
`endif

endmodule

// File: rtl/ram4k_arbiter.sv
// ram4k_arbiter: shares one ram4k between a CPU port (A) and a DMA port (B).
// One RAM access per cycle; ties are broken round-robin (or fixed A priority
// when ARB_FIXED_PRIO_EN is defined, see arb2_pick).
// Ports:
//   clk, rst_n                  : clock (rising edge), async active-low reset
//   req_x, we_x, addr_x, wdata_x: request, held until ack_x (x = a, b)
//   ack_x                       : one-cycle completion pulse
//   rdata_x                     : read data, updated only when ack_x rises
//   ram_addr, ram_in, ram_load  : drive the ram4k address/in/load pins
//   ram_out                     : ram4k combinational read data
module ram4k_arbiter
  import ram4k_arbiter_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              ack_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);

  state_t state, state_nxt;
  logic   last;
  logic   elig_a, elig_b;
  logic   grant_valid, grant_id;

  // A requester still sees its own req during the ack cycle (it drops req
  // only after seeing ack), so it is masked then to avoid a duplicate access.
  // It is also masked while its own access is in progress.
  assign elig_a = req_a & ~ack_a & (state != ST_ACC_A);
  assign elig_b = req_b & ~ack_b & (state != ST_ACC_B);

  arb2_pick u_pick (
    .elig_a      (elig_a),
    .elig_b      (elig_b),
    .last        (last),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_nxt = ST_IDLE;
    if (grant_valid) begin
      state_nxt = (grant_id == PORT_A) ? ST_ACC_A : ST_ACC_B;
    end
  end

  // RAM pin mux, purely from state so the RAM sees a full cycle of stable
  // address/data before the committing edge.
  always_comb begin
    ram_addr = '0;
    ram_in   = '0;
    ram_load = 1'b0;
    case (state)
      ST_ACC_A: begin
        ram_addr = addr_a;
        ram_in   = wdata_a;
        ram_load = we_a;
      end
      ST_ACC_B: begin
        ram_addr = addr_b;
        ram_in   = wdata_b;
        ram_load = we_b;
      end
      default: ;
    endcase
  end

  // State register, round-robin pointer and completion registers. The
  // ram_out sample happens at the same edge that commits a write, hence
  // read-before-write data on write acks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      last    <= PORT_B;
      ack_a   <= 1'b0;
      ack_b   <= 1'b0;
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      state <= state_nxt;
      if (grant_valid) begin
        last <= grant_id;
      end
      ack_a <= (state == ST_ACC_A);
      ack_b <= (state == ST_ACC_B);
      if (state == ST_ACC_A) begin
        rdata_a <= ram_out;
      end
      if (state == ST_ACC_B) begin
        rdata_b <= ram_out;
      end
    end
  end

endmodule
